// File: rtl/pov_pkg.sv
// Shared POV display constants and the column prefetch FSM state type.
package pov_pkg;

    localparam int LED_COUNT  = 52;
    localparam int TEX_WIDTH  = 256;
    localparam int PX_BITS    = 6;
    localparam int COL_BITS   = 8;
    localparam int ADDR_BITS  = 14;
    localparam int DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        READY
    } prefetch_state_t;

endpackage

// File: rtl/column_bank_ram.sv
// Two pixel banks with one write port and one registered read port.
// The array carries no reset; readers gate the output until a bank holds valid data.
module column_bank_ram #(
    parameter int LED_COUNT  = 52,
    parameter int PX_BITS    = 6,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic                  wr_bank_i,
    input  logic [PX_BITS-1:0]    wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_bank_i,
    input  logic [PX_BITS-1:0]    rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2][LED_COUNT];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_bank_i][rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/column_prefetch_buffer.sv
// Double-buffered column cache: prefetches one texture column from ROM into the back bank
// and swaps banks only when the strip restarts at pixel 0. Pixel read latency is 1 cycle.
module column_prefetch_buffer #(
    parameter int LED_COUNT  = pov_pkg::LED_COUNT,
    parameter int TEX_WIDTH  = pov_pkg::TEX_WIDTH,
    parameter int PX_BITS    = pov_pkg::PX_BITS,
    parameter int COL_BITS   = pov_pkg::COL_BITS,
    parameter int ADDR_BITS  = pov_pkg::ADDR_BITS,
    parameter int DATA_WIDTH = pov_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COL_BITS-1:0]   col,
    output logic [ADDR_BITS-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    input  logic [PX_BITS-1:0]    px_num,
    output logic [DATA_WIDTH-1:0] pixel,
    output logic                  busy,
    output logic                  swap_pulse,
    output logic [COL_BITS-1:0]   col_shown
);

    import pov_pkg::*;

    localparam logic [PX_BITS-1:0] LAST_IDX = PX_BITS'(LED_COUNT - 1);
    localparam logic [PX_BITS-1:0] NUM_PX   = PX_BITS'(LED_COUNT);

    prefetch_state_t       state_q;
    logic                  force_q;
    logic [COL_BITS-1:0]   fill_col_q;
    logic [COL_BITS-1:0]   col_shown_q;
    logic [PX_BITS-1:0]    idx_q;
    logic [PX_BITS-1:0]    wr_idx_q;
    logic [PX_BITS-1:0]    px_num_q;
    logic                  iss_vld_q;
    logic                  wr_vld_q;
    logic [ADDR_BITS-1:0]  rom_addr_q;
    logic                  disp_bank_q;
    logic                  disp_valid_q;
    logic                  rd_gate_q;

    logic                  boundary;
    logic                  start_fill;
    logic                  do_swap;
    logic                  rd_bank;
    logic [PX_BITS-1:0]    rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    function automatic logic [ADDR_BITS-1:0] fill_addr(input logic [PX_BITS-1:0]  i,
                                                       input logic [COL_BITS-1:0] c);
        return ADDR_BITS'(i) * ADDR_BITS'(TEX_WIDTH) + ADDR_BITS'(c);
    endfunction

    assign boundary   = (px_num == '0) && (px_num_q != '0);
    // A column change in READY outranks a pending swap: the freshest column wins.
    assign start_fill = ((state_q == IDLE) && (force_q || (col != col_shown_q))) ||
                        ((state_q == READY) && (col != fill_col_q));
    assign do_swap    = (state_q == READY) && (col == fill_col_q) && boundary && !reset;

    // On the swap cycle pixel 0 must already come from the freshly filled bank.
    assign rd_bank = do_swap ? ~disp_bank_q : disp_bank_q;
    assign rd_addr = (px_num < NUM_PX) ? px_num : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            force_q      <= 1'b1;
            fill_col_q   <= '0;
            col_shown_q  <= '0;
            idx_q        <= '0;
            wr_idx_q     <= '0;
            px_num_q     <= '0;
            iss_vld_q    <= 1'b0;
            wr_vld_q     <= 1'b0;
            rom_addr_q   <= '0;
            disp_bank_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            rd_gate_q    <= 1'b0;
        end else begin
            px_num_q  <= px_num;
            rd_gate_q <= (disp_valid_q || do_swap) && (px_num < NUM_PX);
            wr_vld_q  <= iss_vld_q;
            wr_idx_q  <= idx_q;
            case (state_q)
                IDLE, READY: begin
                    if (start_fill) begin
                        fill_col_q <= col;
                        force_q    <= 1'b0;
                        idx_q      <= '0;
                        rom_addr_q <= fill_addr('0, col);
                        iss_vld_q  <= 1'b1;
                        state_q    <= FILL;
                    end else if (do_swap) begin
                        disp_bank_q  <= ~disp_bank_q;
                        col_shown_q  <= fill_col_q;
                        disp_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                FILL: begin
                    if (iss_vld_q) begin
                        if (idx_q == LAST_IDX) begin
                            iss_vld_q <= 1'b0;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            rom_addr_q <= fill_addr(idx_q + 1'b1, fill_col_q);
                        end
                    end
                    if (wr_vld_q && (wr_idx_q == LAST_IDX)) begin
                        state_q <= READY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    column_bank_ram #(
        .LED_COUNT  (LED_COUNT),
        .PX_BITS    (PX_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_banks (
        .clk       (clk),
        .wr_en_i   (wr_vld_q),
        .wr_bank_i (~disp_bank_q),
        .wr_addr_i (wr_idx_q),
        .wr_data_i (rom_data),
        .rd_bank_i (rd_bank),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign rom_addr   = rom_addr_q;
    assign pixel      = rd_gate_q ? rd_data : '0;
    assign busy       = (state_q == FILL);
    assign swap_pulse = do_swap;
    assign col_shown  = col_shown_q;

endmodule

// File: tb/tb_column_prefetch_buffer.sv
// Directed bench for column_prefetch_buffer; ROM model returns its own address as data.
module tb_column_prefetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  col;
    logic [13:0] rom_addr;
    logic [23:0] rom_data;
    logic [5:0]  px_num;
    logic [23:0] pixel;
    logic        busy;
    logic        swap_pulse;
    logic [7:0]  col_shown;

    int n_total = 0;
    int n_bad   = 0;

    int   pix [0:51];
    logic sp_seen;
    int   swaps;
    int   n_fill;
    int   a0, a1, a51;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= 24'(rom_addr);

    column_prefetch_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .col        (col),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .px_num     (px_num),
        .pixel      (pixel),
        .busy       (busy),
        .swap_pulse (swap_pulse),
        .col_shown  (col_shown)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel index; returns with pixel holding the read result for it.
    task automatic present(input logic [5:0] k);
        px_num = k;
        @(negedge clk);
        sp_seen = swap_pulse;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame();
        swaps = 0;
        for (int k = 1; k < 52; k++) begin
            present(6'(k));
            pix[k] = int'(pixel);
            if (sp_seen) swaps++;
        end
        present(6'd0);
        pix[0] = int'(pixel);
        if (sp_seen) swaps++;
    endtask

    task automatic wait_fill(output int n, output int f0, output int f1, output int f51);
        int guard;
        n = 0; guard = 0; f0 = -1; f1 = -1; f51 = -1;
        @(negedge clk);
        while (!busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        while (busy && n < 200) begin
            if (n == 0)  f0  = int'(rom_addr);
            if (n == 1)  f1  = int'(rom_addr);
            if (n == 51) f51 = int'(rom_addr);
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; col = 8'd0; px_num = 6'd0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_pixel", 32'(pixel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_swap", 32'(swap_pulse), 0);
        chk("rst_col_shown", 32'(col_shown), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // first fill after reset, column 0
        wait_fill(n_fill, a0, a1, a51);
        chk("fill0_len", n_fill, 53);
        chk("fill0_a0", a0, 0);
        chk("fill0_a1", a1, 256);
        chk("fill0_a51", a51, 13056);
        present(6'd10); chk("preswap_px10", 32'(pixel), 0);
        present(6'd60); chk("preswap_px60", 32'(pixel), 0);
        run_frame();
        chk("f0_swaps", swaps, 1);
        chk("f0_preswap_px25", pix[25], 0);
        run_frame();
        chk("f0b_swaps", swaps, 0);
        chk("f0b_px1", pix[1], 256);
        chk("f0b_px37", pix[37], 9472);
        chk("f0b_px51", pix[51], 13056);
        present(6'd60); chk("postswap_px60", 32'(pixel), 0);

        // column 5, then change to 6 mid-frame at pixel 20
        col = 8'd5;
        wait_fill(n_fill, a0, a1, a51);
        chk("fill5_a1", a1, 261);
        run_frame();
        chk("f5_swaps", swaps, 1);
        chk("f5_px0", pix[0], 5);
        chk("f5_col_shown", 32'(col_shown), 5);
        swaps = 0;
        for (int k = 1; k < 52; k++) begin
            present(6'(k));
            pix[k] = int'(pixel);
            if (k == 20) col = 8'd6;
        end
        present(6'd0);
        chk("mid_px21", pix[21], 21 * 256 + 5);
        chk("mid_px51", pix[51], 51 * 256 + 5);
        chk("mid_bnd_noswap", 32'(sp_seen), 0);
        chk("mid_bnd_px0", 32'(pixel), 5);
        run_frame();
        chk("f6_swaps", swaps, 1);
        chk("f6_px0", pix[0], 6);
        chk("f6_col_shown", 32'(col_shown), 6);
        run_frame();
        chk("f6b_swaps", swaps, 0);
        chk("f6b_px1", pix[1], 262);
        chk("f6b_px51", pix[51], 51 * 256 + 6);

        // column change during FILL: no abort, then refill with the newest column
        col = 8'd7;
        fork
            wait_fill(n_fill, a0, a1, a51);
            begin
                repeat (10) tick();
                col = 8'd8;
            end
        join
        chk("fill7_len", n_fill, 53);
        chk("fill7_a0", a0, 7);
        wait_fill(n_fill, a0, a1, a51);
        chk("fill8_len", n_fill, 53);
        chk("fill8_a1", a1, 264);
        run_frame();
        chk("f8_swaps", swaps, 1);
        chk("f8_px0", pix[0], 8);
        chk("f8_col_shown", 32'(col_shown), 8);

        // column change on the same cycle as a boundary in READY: refill, no swap
        col = 8'd9;
        wait_fill(n_fill, a0, a1, a51);
        chk("fill9_a0", a0, 9);
        for (int k = 1; k < 52; k++) present(6'(k));
        col = 8'd10;
        present(6'd0);
        chk("race_noswap", 32'(sp_seen), 0);
        chk("race_col_shown", 32'(col_shown), 8);
        wait_fill(n_fill, a0, a1, a51);
        chk("fill10_len", n_fill, 53);
        chk("fill10_a0", a0, 10);
        run_frame();
        chk("f10_swaps", swaps, 1);
        chk("f10_col_shown", 32'(col_shown), 10);

        // reset at FILL cycle 30
        col = 8'd3;
        tick();
        repeat (30) tick();
        @(negedge clk);
        chk("fill3_c30_busy", 32'(busy), 1);
        chk("fill3_c30_addr", 32'(rom_addr), 30 * 256 + 3);
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        chk("mid_rst_rom_addr", 32'(rom_addr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_swap", 32'(swap_pulse), 0);
        chk("mid_rst_col_shown", 32'(col_shown), 0);
        chk("mid_rst_pixel", 32'(pixel), 0);
        reset = 1'b0;
        wait_fill(n_fill, a0, a1, a51);
        chk("refill3_len", n_fill, 53);
        chk("refill3_a0", a0, 3);
        present(6'd7); chk("blank_px7", 32'(pixel), 0);
        run_frame();
        chk("f3_swaps", swaps, 1);
        chk("f3_blank_px7", pix[7], 0);
        chk("f3_px0", pix[0], 3);
        chk("f3_col_shown", 32'(col_shown), 3);
        run_frame();
        chk("f3b_px7", pix[7], 7 * 256 + 3);

        // wrap 255 -> 0
        col = 8'd255;
        wait_fill(n_fill, a0, a1, a51);
        chk("fill255_a1", a1, 511);
        run_frame();
        chk("f255_px0", pix[0], 255);
        col = 8'd0;
        wait_fill(n_fill, a0, a1, a51);
        chk("wrap_len", n_fill, 53);
        chk("wrap_a0", a0, 0);
        chk("wrap_a1", a1, 256);
        chk("wrap_a51", a51, 13056);
        run_frame();
        chk("wrap_swaps", swaps, 1);
        chk("wrap_col_shown", 32'(col_shown), 0);
        run_frame();
        chk("wrap_px1", pix[1], 256);
        chk("wrap_px51", pix[51], 13056);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
